// File: rtl/mrv1_imem_fetch_ctrl_if.sv
// mrv1_imem_fetch_ctrl_if: scheduler, IMEM, flush and fetch-buffer signals of the fetch controller
interface mrv1_imem_fetch_ctrl_if #(
  parameter int PC_WIDTH_P = 32,
  parameter int NUM_THREADS_P = 8
);
  localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P);
  logic sched_vld_i;
  logic sched_rdy_o;
  logic [TID_WIDTH_LP-1:0] sched_tid_i;
  logic [PC_WIDTH_P-1:0] sched_pc_i;
  logic imem_req_vld_o;
  logic imem_req_rdy_i;
  logic [31:0] imem_req_addr_o;
  logic imem_resp_vld_i;
  logic [31:0] imem_resp_data_i;
  logic flush_vld_i;
  logic [TID_WIDTH_LP-1:0] flush_tid_i;
  logic ifq_deq_i;
  logic fetch_vld_o;
  logic [31:0] fetch_data_o;
  logic [PC_WIDTH_P-1:0] fetch_pc_o;
  logic [TID_WIDTH_LP-1:0] fetch_tid_o;
  logic fetch_done_vld_o;
  logic [TID_WIDTH_LP-1:0] fetch_done_tid_o;
  logic [PC_WIDTH_P-1:0] fetch_done_pc_o;
  logic busy_o;
  modport slave (
    input sched_vld_i, sched_tid_i, sched_pc_i, imem_req_rdy_i, imem_resp_vld_i, imem_resp_data_i,
    input flush_vld_i, flush_tid_i, ifq_deq_i,
    output sched_rdy_o, imem_req_vld_o, imem_req_addr_o, fetch_vld_o, fetch_data_o, fetch_pc_o,
    output fetch_tid_o, fetch_done_vld_o, fetch_done_tid_o, fetch_done_pc_o, busy_o
  );
  modport master (
    output sched_vld_i, sched_tid_i, sched_pc_i, imem_req_rdy_i, imem_resp_vld_i, imem_resp_data_i,
    output flush_vld_i, flush_tid_i, ifq_deq_i,
    input sched_rdy_o, imem_req_vld_o, imem_req_addr_o, fetch_vld_o, fetch_data_o, fetch_pc_o,
    input fetch_tid_o, fetch_done_vld_o, fetch_done_tid_o, fetch_done_pc_o, busy_o
  );
endinterface

// File: rtl/mrv1_imem_fetch_ctrl.sv
// mrv1_imem_fetch_ctrl: credit-throttled IMEM request stage with in-order tag FIFO and epoch-based stale-response drop
module mrv1_imem_fetch_ctrl #(
  parameter int PC_WIDTH_P = 32,
  parameter int NUM_THREADS_P = 8,
  parameter int MAX_OSTD_P = 4,
  parameter int IFQ_CREDITS_P = 3
) (
  input logic clk_i,
  input logic rst_i,
  mrv1_imem_fetch_ctrl_if.slave bus
);
  localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P);
  localparam int PW = MAX_OSTD_P > 1 ? $clog2(MAX_OSTD_P) : 1;
  localparam int OW = $clog2(MAX_OSTD_P + 1);
  localparam int CW = $clog2(IFQ_CREDITS_P + 2);
  typedef struct packed {
    logic [TID_WIDTH_LP-1:0] tid;
    logic [PC_WIDTH_P-1:0] pc;
    logic ep;
  } tag_t;
  tag_t req_q, head;
  tag_t fifo_q [MAX_OSTD_P];
  logic req_vld_q, seen_hs_q;
  logic [PW-1:0] wr_q, rd_q;
  logic [OW-1:0] ostd_q;
  logic [CW-1:0] cred_q;
  logic [NUM_THREADS_P-1:0] ep_q, ep_d;
  logic room, hs, acc, pop, keep, drop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(MAX_OSTD_P - 1) ? '0 : p + 1'b1;
  endfunction
  assign room = ostd_q < OW'(MAX_OSTD_P);
  assign bus.imem_req_vld_o = req_vld_q && room;
  assign bus.imem_req_addr_o = 32'(req_q.pc) & 32'hffff_fffc;
  assign bus.sched_rdy_o = rst_i && cred_q != '0 && (!req_vld_q || (bus.imem_req_rdy_i && room));
  assign bus.busy_o = req_vld_q || ostd_q != '0;
  assign hs = bus.imem_req_vld_o && bus.imem_req_rdy_i;
  assign acc = bus.sched_vld_i && bus.sched_rdy_o;
  assign pop = bus.imem_resp_vld_i && ostd_q != '0;
  assign head = fifo_q[rd_q];
  assign ep_d = ep_q ^ (NUM_THREADS_P'(bus.flush_vld_i) << bus.flush_tid_i);
  assign keep = pop && head.ep == ep_q[head.tid] && !(bus.flush_vld_i && bus.flush_tid_i == head.tid);
  assign drop = pop && !keep;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      req_vld_q <= 1'b0;
      req_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      ostd_q <= '0;
      cred_q <= CW'(IFQ_CREDITS_P);
      ep_q <= '0;
      seen_hs_q <= 1'b0;
      bus.fetch_vld_o <= 1'b0;
      bus.fetch_data_o <= '0;
      bus.fetch_pc_o <= '0;
      bus.fetch_tid_o <= '0;
      bus.fetch_done_vld_o <= 1'b0;
      bus.fetch_done_tid_o <= '0;
      bus.fetch_done_pc_o <= '0;
    end else begin
      req_vld_q <= acc || (req_vld_q && !hs);
      if (acc) req_q <= '{bus.sched_tid_i, bus.sched_pc_i, ep_d[bus.sched_tid_i]};
      if (hs) begin
        fifo_q[wr_q] <= req_q;
        wr_q <= nxt(wr_q);
      end
      if (pop) rd_q <= nxt(rd_q);
      ostd_q <= ostd_q + OW'(hs) - OW'(pop);
      cred_q <= cred_q - CW'(acc) + CW'(bus.ifq_deq_i) + CW'(drop);
      ep_q <= ep_d;
      seen_hs_q <= seen_hs_q || hs;
      bus.fetch_vld_o <= keep;
      bus.fetch_done_vld_o <= keep;
      if (keep) begin
        bus.fetch_data_o <= bus.imem_resp_data_i;
        bus.fetch_pc_o <= head.pc;
        bus.fetch_tid_o <= head.tid;
        bus.fetch_done_tid_o <= head.tid;
        bus.fetch_done_pc_o <= head.pc + PC_WIDTH_P'(4);
      end
    end
  end
  cred_bound: assert property (@(posedge clk_i) disable iff (!rst_i) cred_q <= CW'(IFQ_CREDITS_P));
  resp_tracked: assert property (@(posedge clk_i) disable iff (!rst_i) !(bus.imem_resp_vld_i && ostd_q == '0 && seen_hs_q));
endmodule
